// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared code, state and side encodings for the buzzer scheduler
package buzzer_pkg;
    localparam logic [1:0] CODE_OFF   = 2'b00;
    localparam logic [1:0] CODE_BOTH  = 2'b01;
    localparam logic [1:0] CODE_CLOSE = 2'b10;
    localparam logic [1:0] CODE_RSVD  = 2'b11;
    localparam logic [1:0] SIDE_NONE  = 2'b00;
    localparam logic [1:0] SIDE_LEFT  = 2'b01;
    localparam logic [1:0] SIDE_RIGHT = 2'b10;
    typedef enum logic [1:0] {IDLE, BEEP_L, BEEP_R, GAP} state_t;
    function automatic logic [1:0] sanitize(logic [1:0] c);
        return c == CODE_RSVD ? CODE_OFF : c;
    endfunction
endpackage

// File: rtl/buzzer_scheduler_if.sv
// buzzer_scheduler_if: classifier codes in, buzzer pins and status out
interface buzzer_scheduler_if;
    logic [1:0] left_code;
    logic [1:0] right_code;
    logic       buzz_left;
    logic       buzz_right;
    logic [1:0] active_side;
    logic       busy;
    modport master (output left_code, right_code, input buzz_left, buzz_right, active_side, busy);
    modport slave  (input left_code, right_code, output buzz_left, buzz_right, active_side, busy);
endinterface

// File: rtl/buzzer_scheduler_code_debouncer.sv
// code_debouncer: accepts a new 2-bit code after DEBOUNCE_CYCLES equal samples
module code_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] raw,
    output logic [1:0] q
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]  cand;
    logic [CW-1:0] cnt;
    logic [CW:0] hit;
    always_comb hit = raw == cand ? {1'b0, cnt} + 1'b1 : (CW+1)'(1);
    always_ff @(posedge clk)
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
            q    <= '0;
        end else begin
            cand <= raw;
            if (raw == q) cnt <= '0;
            else if (hit == (CW+1)'(DEBOUNCE_CYCLES)) begin
                q   <= raw;
                cnt <= '0;
            end else cnt <= hit[CW-1:0];
        end
endmodule

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: debounces left/right codes and time-shares one tone driver between buzzers
module buzzer_scheduler
    import buzzer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEAT_CYCLES     = 8,
    parameter int TONE_DIV        = 2
) (
    input logic clk,
    input logic reset,
    buzzer_scheduler_if.slave bus
);
    localparam int BW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
    localparam int TW = TONE_DIV > 1 ? $clog2(TONE_DIV) : 1;
    state_t        state;
    logic [1:0]    last_side, lq, rq, sel;
    logic [BW-1:0] bc;
    logic [TW-1:0] tc;
    logic          ph, gap_next, both_off, no_gap, end_beat, tone_wrap;
    code_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .reset(reset), .raw(sanitize(bus.left_code)), .q(lq));
    code_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .reset(reset), .raw(sanitize(bus.right_code)), .q(rq));
    always_comb begin
        both_off  = lq == CODE_OFF && rq == CODE_OFF;
        no_gap    = lq == CODE_BOTH && rq == CODE_BOTH;
        sel       = lq != CODE_OFF && rq == CODE_OFF ? SIDE_LEFT :
                    rq != CODE_OFF && lq == CODE_OFF ? SIDE_RIGHT :
                    last_side == SIDE_LEFT ? SIDE_RIGHT : SIDE_LEFT;
        end_beat  = bc == BW'(BEAT_CYCLES - 1);
        tone_wrap = tc == TW'(TONE_DIV - 1);
    end
    // gap_next remembers whether the current beat owes a GAP before the next decision
    always_ff @(posedge clk)
        if (reset || both_off) begin
            if (reset) last_side <= SIDE_RIGHT;
            state           <= IDLE;
            bc              <= '0;
            tc              <= '0;
            ph              <= 1'b0;
            gap_next        <= 1'b0;
            bus.buzz_left   <= 1'b0;
            bus.buzz_right  <= 1'b0;
            bus.active_side <= SIDE_NONE;
            bus.busy        <= 1'b0;
        end else if (state == IDLE || (end_beat && !gap_next)) begin
            state           <= sel == SIDE_LEFT ? BEEP_L : BEEP_R;
            last_side       <= sel;
            bc              <= '0;
            tc              <= '0;
            ph              <= 1'b1;
            gap_next        <= !no_gap;
            bus.buzz_left   <= sel == SIDE_LEFT;
            bus.buzz_right  <= sel == SIDE_RIGHT;
            bus.active_side <= sel;
            bus.busy        <= 1'b1;
        end else if (end_beat) begin
            state           <= GAP;
            bc              <= '0;
            tc              <= '0;
            ph              <= 1'b0;
            gap_next        <= 1'b0;
            bus.buzz_left   <= 1'b0;
            bus.buzz_right  <= 1'b0;
            bus.active_side <= SIDE_NONE;
            bus.busy        <= 1'b1;
        end else begin
            bc             <= bc + 1'b1;
            tc             <= tone_wrap ? '0 : tc + 1'b1;
            ph             <= ph ^ tone_wrap;
            bus.buzz_left  <= state == BEEP_L && (ph ^ tone_wrap);
            bus.buzz_right <= state == BEEP_R && (ph ^ tone_wrap);
        end
endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler: scoreboard bench comparing the scheduler against a cycle-level behavioural model
module tb_buzzer_scheduler;
    localparam int DC = 4;
    localparam int BC = 8;
    localparam int TD = 2;
    typedef struct packed {
        logic       bl;
        logic       br;
        logic [1:0] as;
        logic       busy;
    } obs_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    buzzer_scheduler_if bus();
    buzzer_scheduler #(.DEBOUNCE_CYCLES(DC), .BEAT_CYCLES(BC), .TONE_DIV(TD)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;
    // model: qualified code = value seen DC samples in a row; seg 0 idle, 1 left, 2 right, 3 gap
    logic [1:0] ql = 0, qr = 0, lv = 0, rv = 0;
    int lrun = 0, rrun = 0, seg = 0, age = 0, last = 2;
    bit owe_gap = 0;
    always @(posedge clk) begin : model
        logic [1:0] sl, sr;
        bit lo, ro;
        obs_t e;
        if (reset) begin
            ql = 0; qr = 0; lv = 0; rv = 0; lrun = 0; rrun = 0;
            seg = 0; age = 0; last = 2; owe_gap = 0;
        end else begin
            lo = ql != 0;
            ro = qr != 0;
            if (!lo && !ro) begin
                seg = 0; age = 0;
            end else if (seg == 0 || (age == BC - 1 && !owe_gap)) begin
                seg = (lo && !ro) ? 1 : (ro && !lo) ? 2 : (last == 1 ? 2 : 1);
                last = seg;
                age = 0;
                owe_gap = !(ql == 1 && qr == 1);
            end else if (age == BC - 1) begin
                seg = 3; age = 0; owe_gap = 0;
            end else age++;
            sl = bus.left_code == 2'b11 ? 2'b00 : bus.left_code;
            sr = bus.right_code == 2'b11 ? 2'b00 : bus.right_code;
            lrun = sl == lv ? lrun + 1 : 1;
            lv = sl;
            rrun = sr == rv ? rrun + 1 : 1;
            rv = sr;
            if (lrun >= DC) ql = lv;
            if (rrun >= DC) qr = rv;
        end
        e.bl   = seg == 1 && (age / TD) % 2 == 0;
        e.br   = seg == 2 && (age / TD) % 2 == 0;
        e.as   = seg == 1 ? 2'b01 : seg == 2 ? 2'b10 : 2'b00;
        e.busy = seg != 0;
        exp_q.push_back(e);
    end
    always @(negedge clk) begin : monitor
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.buzz_left, bus.buzz_right, bus.active_side, bus.busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual bl=%b br=%b side=%b busy=%b required bl=%b br=%b side=%b busy=%b",
                         $time, a.bl, a.br, a.as, a.busy, e.bl, e.br, e.as, e.busy);
            end
            checks++;
            if (bus.buzz_left === 1'b1 && bus.buzz_right === 1'b1) begin
                errors++;
                $display("FAIL overlap t=%0t actual both buzzers 1 required at most one", $time);
            end
        end
    end
    task automatic drive(input logic r, input logic [1:0] l, input logic [1:0] rc, input int n);
        reset = r;
        bus.left_code = l;
        bus.right_code = rc;
        repeat (n) @(negedge clk);
    endtask
    initial begin
        bus.left_code = 2'b10;
        bus.right_code = 2'b00;
        drive(1, 2'b10, 2'b00, 3);
        drive(0, 2'b10, 2'b00, 40);
        drive(0, 2'b00, 2'b00, 10);
        drive(0, 2'b10, 2'b00, 3);
        drive(0, 2'b00, 2'b00, 10);
        drive(0, 2'b01, 2'b01, 40);
        drive(0, 2'b00, 2'b00, 10);
        drive(0, 2'b10, 2'b10, 45);
        drive(0, 2'b10, 2'b10, 9);
        drive(0, 2'b00, 2'b00, 10);
        drive(0, 2'b00, 2'b10, 9);
        drive(1, 2'b00, 2'b10, 1);
        drive(0, 2'b11, 2'b11, 10);
        drive(0, 2'b01, 2'b10, 40);
        for (int i = 0; i < 800; i++) begin
            logic [1:0] l, rc;
            l = bus.left_code;
            rc = bus.right_code;
            if ($urandom_range(0, 5) == 0) begin
                l = 2'($urandom_range(0, 3));
                rc = 2'($urandom_range(0, 3));
            end
            drive($urandom_range(0, 199) == 0, l, rc, 1);
        end
        drive(0, 2'b00, 2'b00, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/buzzer_scheduler.md
# buzzer_scheduler

Sequences the audible alert for the obstacle detector. It accepts the per-side buzzer codes produced by the classifier and debounces each one. It then time-shares a single tone driver between the left and right buzzers, so at most one buzzer sounds in any cycle. It sits between the classifier's left/right code outputs and the buzzer pins.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive equal samples required to accept a new code (≥1).
- BEAT_CYCLES, 8: length of one beep beat and of one gap (≥2).
- TONE_DIV, 2: tone half-period in cycles (≥1).

- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high.
- left_code  in  2  left request: 00 off, 01 both close, 10 close, 11 reserved (treated as 00).
- right_code  in  2  right request, same encoding.
- buzz_left  out  1  left buzzer tone.
- buzz_right  out  1  right buzzer tone.
- active_side  out  2  00 none, 01 left, 10 right.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Debounce per side: candidate register plus counter. The counter counts consecutive edges where the raw code equals the candidate and differs from the qualified code.
  - On the DEBOUNCE_CYCLES-th such edge, the qualified code takes the raw value.
  - Any change of the raw code restarts the count at 1 with the new candidate.
  - Code 11 is mapped to 00 before the debouncer.
- FSM states: IDLE, BEEP_L, BEEP_R, GAP. The register last_side resets to RIGHT.
- Decision point: every cycle in IDLE, plus the last cycle of each beat or gap.
  - Both qualified codes 00 → IDLE.
  - Both qualified codes 01 → beep the side opposite last_side, with no GAP afterwards (strict alternation).
  - Exactly one side nonzero → beep that side, then GAP.
  - Both nonzero, any other combination → beep the side opposite last_side, then GAP (round robin).
- On entering BEEP_L/BEEP_R: update last_side and clear the beat and tone counters.
- During a beep, the selected buzzer output is 1 for TONE_DIV cycles, then 0 for TONE_DIV cycles, repeating from the first beat cycle. The unselected buzzer is 0.
- Abort: if both qualified codes become 00 mid-beat or mid-gap, go to IDLE on the next edge. Otherwise, code changes take effect only at the next decision point.
- active_side mirrors the state: BEEP_L → 01, BEEP_R → 10, otherwise 00.

## Timing
- Reset drives buzz_left, buzz_right, active_side and busy to 0, and the state to IDLE. Qualified codes, candidates and all counters clear to 0. last_side is set to RIGHT.
  - A reset mid-beat zeroes all outputs in the cycle after the reset edge.
- All outputs are registered; no combinational path runs from the code inputs to the outputs.
- Latency: the raw code is first sampled at edge e. The qualified code updates at edge e+DEBOUNCE_CYCLES−1, the FSM enters the beep state at edge e+DEBOUNCE_CYCLES, and the buzzer is high from that edge. With default parameters, the first tone cycle starts 4 edges after the first sample.
- A beat and a gap each last exactly BEAT_CYCLES cycles. There are no idle cycles between a beat and the following beat or gap.
- Counter widths are $clog2 of the respective parameter, with a minimum of 1. Counters never wrap: they are cleared at every state entry.
- Simultaneous change on both raw codes: each side is debounced independently, and the decision uses the qualified values from the same edge.

## Structure
- Package buzzer_pkg: code constants CODE_OFF, CODE_BOTH, CODE_CLOSE, CODE_RSVD; state enum; side encoding SIDE_NONE/LEFT/RIGHT.
- Sub-module code_debouncer (parameter DEBOUNCE_CYCLES, 2-bit), instantiated once per side. The FSM and the tone generator stay in the top level.

## Test plan
Default parameters apply throughout.
- Reset held 3 cycles while left_code=10 → all outputs 0 and busy=0 during reset and the cycle after.
- left_code=10 held, right_code=00 → buzz_left follows 1,1,0,0,1,1,0,0, then 8 zeros (GAP), repeating; buzz_right is always 0; active_side alternates between 01 and 00.
- left_code=10 for 3 cycles, then 00 → no qualification; busy stays 0.
- Both codes 01 → 8-cycle left beat then 8-cycle right beat, alternating with no gap; left goes first after reset.
- Both codes 10 → left beat, gap, right beat, gap; buzz_left and buzz_right are never high together.
- Mid-beat, both codes drop to 00 → IDLE and outputs 0 from 4 edges after the first sample of 00. Separately, asserting reset mid-beat gives outputs 0 on the next cycle.
